// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, flag and enable control for an external 2**ADDR_WIDTH-entry FIFO memory.
// Optional build macro FIFO_CTRL_ERR_FLAGS_EN enables sticky overflow/underflow registers;
// without it both ports are tied to 0.
// DATA_WIDTH describes the attached memory only; no data passes through this block.
module fifo_ctrl #(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter int unsigned AFULL_LEVEL = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  wen,
  output logic                  ren,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  rd_valid,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;

  // Reject a zero-width memory description at elaboration time.
  if (DATA_WIDTH == 0) begin : g_bad_data_width
    $error("fifo_ctrl: DATA_WIDTH must be at least 1");
  end

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic            rd_valid_q, rd_valid_d;

  // Occupancy flags and memory enables, derived from registered pointers.
  always_comb begin
    waddr       = wptr_q[ADDR_WIDTH-1:0];
    raddr       = rptr_q[ADDR_WIDTH-1:0];
    count       = wptr_q - rptr_q;
    empty       = (wptr_q == rptr_q);
    full        = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                  (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);
    almost_full = (count >= PtrW'(AFULL_LEVEL));
    // Reset masks the enables so no memory access happens while held in reset.
    wen         = rst_n & push & ~full & ~flush;
    ren         = rst_n & pop & ~empty & ~flush;
    rd_valid    = rd_valid_q;
  end

  // Next pointer values; flush returns both pointers to zero.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rd_valid_d = ren;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wen) wptr_d = wptr_q + PtrW'(1);
      if (ren) rptr_d = rptr_q + PtrW'(1);
    end
  end

  // Pointer and read-valid registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags; flush neither sets nor clears them.
  always_comb begin
    overflow_d  = overflow_q  | (push & full  & ~flush);
    underflow_d = underflow_q | (pop  & empty & ~flush);
  end

  // Error flag registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios followed by random traffic,
// compared against an occupancy/transaction-count model.
module tb_fifo_ctrl;

  localparam int unsigned AW    = 3;
  localparam int          DEPTH = 8;
  localparam int          AFULL = 6;

  logic          clk = 1'b0;
  logic          rst_n, push, pop, flush;
  logic [AW-1:0] waddr, raddr;
  logic          wen, ren, full, empty, almost_full, rd_valid, overflow, underflow;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  // Reference model: occupancy, total accepted writes/reads since last clear.
  int  m_cnt = 0;
  int  m_wr  = 0;
  int  m_rd  = 0;
  bit  m_rdv = 0;
  bit  m_ovf = 0;
  bit  m_unf = 0;

  fifo_ctrl #(.DATA_WIDTH(4), .ADDR_WIDTH(AW), .AFULL_LEVEL(AFULL)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
    .waddr(waddr), .raddr(raddr), .wen(wen), .ren(ren),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .rd_valid(rd_valid), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check mid-cycle outputs against the model, advance the model.
  task automatic step(input bit p, input bit po, input bit f, input bit rn = 1'b1);
    bit acc_w, acc_r, exp_ovf, exp_unf;
    rst_n = rn; push = p; pop = po; flush = f;
    @(negedge clk);
    acc_w = rn && p  && (m_cnt < DEPTH) && !f;
    acc_r = rn && po && (m_cnt > 0)     && !f;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    exp_ovf = m_ovf; exp_unf = m_unf;
`else
    exp_ovf = 1'b0; exp_unf = 1'b0;
`endif
    chk("count",       int'(count),       m_cnt);
    chk("empty",       int'(empty),       int'(m_cnt == 0));
    chk("full",        int'(full),        int'(m_cnt == DEPTH));
    chk("almost_full", int'(almost_full), int'(m_cnt >= AFULL));
    chk("waddr",       int'(waddr),       m_wr % DEPTH);
    chk("raddr",       int'(raddr),       m_rd % DEPTH);
    chk("wen",         int'(wen),         int'(acc_w));
    chk("ren",         int'(ren),         int'(acc_r));
    chk("rd_valid",    int'(rd_valid),    int'(m_rdv));
    chk("overflow",    int'(overflow),    int'(exp_ovf));
    chk("underflow",   int'(underflow),   int'(exp_unf));
    if (!rn) begin
      m_cnt = 0; m_wr = 0; m_rd = 0; m_rdv = 0; m_ovf = 0; m_unf = 0;
    end else if (f) begin
      m_cnt = 0; m_wr = 0; m_rd = 0; m_rdv = 0;
    end else begin
      if (p  && m_cnt == DEPTH) m_ovf = 1;
      if (po && m_cnt == 0)     m_unf = 1;
      m_wr  += int'(acc_w);
      m_rd  += int'(acc_r);
      m_cnt += int'(acc_w) - int'(acc_r);
      m_rdv  = acc_r;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    // Reset held with requests active: enables stay low.
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    // Eight pushes to full, then a ninth while full.
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    step(1, 0, 0);
    // Drain to empty, then an extra pop.
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    // Wrap-around from cleared pointers.
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    step(0, 0, 0);
    // Simultaneous push/pop at count 3, at full, and at empty.
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    step(1, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    step(1, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    // Flush at count 4 together with push and pop.
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    step(1, 1, 1);
    step(0, 0, 0);
    // Read issued just before reset is discarded.
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0);
    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 79) != 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
